// File: rtl/rect_painter.sv
// Rectangle fill engine: clips a rectangle to the screen and streams one
// frame-memory write per cycle in row-major order, then emits a done pulse.
module rect_painter #(
    parameter int SCR_WIDTH      = 112,
    parameter int SCR_HEIGHT     = 112,
    parameter int ADDR_SIZE      = 14,
    parameter int MEM_ADDR_START = 0,
    parameter int DATA_W         = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 in_cont_signal,
    input  logic [6:0]           x0,
    input  logic [6:0]           y0,
    input  logic [7:0]           w,
    input  logic [7:0]           h,
    input  logic [DATA_W-1:0]    color,
    output logic [ADDR_SIZE-1:0] write_addr,
    output logic [DATA_W-1:0]    write_data,
    output logic                 write_en,
    output logic                 busy,
    output logic                 out_cont_signal
);

    typedef enum logic [1:0] {S_IDLE, S_PAINT, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [7:0]           eff_w_q, eff_w_d;
    logic [7:0]           col_q, col_d;
    logic [7:0]           row_q, row_d;
    logic [ADDR_SIZE-1:0] addr_q, addr_d;
    logic [ADDR_SIZE-1:0] base_q, base_d;
    logic [DATA_W-1:0]    color_q, color_d;

    logic [31:0] rem_w, rem_h;
    logic [7:0]  clip_w, clip_h;

    // Space left to the right/bottom edge; zero when the origin is off-screen.
    always_comb begin
        rem_w  = (32'(x0) < 32'(SCR_WIDTH))  ? 32'(SCR_WIDTH)  - 32'(x0) : '0;
        rem_h  = (32'(y0) < 32'(SCR_HEIGHT)) ? 32'(SCR_HEIGHT) - 32'(y0) : '0;
        clip_w = (32'(w) < rem_w) ? w : rem_w[7:0];
        clip_h = (32'(h) < rem_h) ? h : rem_h[7:0];
    end

    always_comb begin
        state_d = state_q;
        eff_w_d = eff_w_q;
        col_d   = col_q;
        row_d   = row_q;
        addr_d  = addr_q;
        base_d  = base_q;
        color_d = color_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_cont_signal) begin
                    if (clip_w == 8'd0 || clip_h == 8'd0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_PAINT;
                        color_d = color;
                        eff_w_d = clip_w;
                        col_d   = clip_w - 8'd1;
                        row_d   = clip_h - 8'd1;
                        // Multiply only at accept time; the per-pixel path is adders.
                        addr_d  = ADDR_SIZE'(MEM_ADDR_START + 32'(x0) + 32'(y0) * SCR_WIDTH);
                        base_d  = addr_d;
                    end
                end
            end
            S_PAINT: begin
                if (col_q == 8'd0) begin
                    if (row_q == 8'd0) begin
                        state_d = S_DONE;
                    end else begin
                        row_d  = row_q - 8'd1;
                        col_d  = eff_w_q - 8'd1;
                        base_d = base_q + ADDR_SIZE'(SCR_WIDTH);
                        addr_d = base_d;
                    end
                end else begin
                    col_d  = col_q - 8'd1;
                    addr_d = addr_q + ADDR_SIZE'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            eff_w_q <= '0;
            col_q   <= '0;
            row_q   <= '0;
            addr_q  <= '0;
            base_q  <= '0;
            color_q <= '0;
        end else begin
            state_q <= state_d;
            eff_w_q <= eff_w_d;
            col_q   <= col_d;
            row_q   <= row_d;
            addr_q  <= addr_d;
            base_q  <= base_d;
            color_q <= color_d;
        end
    end

    assign write_addr      = addr_q;
    assign write_data      = color_q;
    assign write_en        = (state_q == S_PAINT);
    assign out_cont_signal = (state_q == S_DONE);
    assign busy            = (state_q != S_IDLE);

endmodule
